// File: rtl/ram_1w_nr_clr.sv
// Multi-read-port distributed RAM: one byte-enabled synchronous write port,
// NRD combinational read ports, and a clear engine that sweeps CLR_VAL into every word.
module ram_1w_nr_clr #(
    parameter int unsigned       DWIDTH  = 32,
    parameter int unsigned       AWIDTH  = 6,
    parameter int unsigned       DEPTH   = 1 << AWIDTH,
    parameter int unsigned       NRD     = 2,
    parameter bit                WR_FWD  = 1'b0,
    parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   we,
    input  logic [DWIDTH/8-1:0]    wbe,
    input  logic [AWIDTH-1:0]      wa,
    input  logic [DWIDTH-1:0]      wd,
    input  logic [NRD*AWIDTH-1:0]  ra,
    output logic [NRD*DWIDTH-1:0]  rd
);

    localparam int unsigned       NBYTE   = DWIDTH / 8;
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

    if (DWIDTH % 8 != 0) begin : g_bad_dwidth
        $error("ram_1w_nr_clr: DWIDTH must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << AWIDTH)) begin : g_bad_depth
        $error("ram_1w_nr_clr: DEPTH must be in 1 .. 2**AWIDTH");
    end
    if (NRD < 1) begin : g_bad_nrd
        $error("ram_1w_nr_clr: NRD must be at least 1");
    end

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state;
    logic [AWIDTH-1:0]   cnt;
    logic [DWIDTH-1:0]   mem [DEPTH];
    logic                wa_ok;

    assign wa_ok = {1'b0, wa} < DEPTH_W;
    assign busy  = (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + AWIDTH'(1);
                    if (cnt == LAST) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (clr) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // A user write in IDLE still lands on the edge that accepts clr; the sweep overwrites it later.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= CLR_VAL;
            end else if (we && wa_ok) begin
                for (int unsigned i = 0; i < NBYTE; i++) begin
                    if (wbe[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [AWIDTH-1:0] rak;
            logic [DWIDTH-1:0] word;
            rak  = ra[k*AWIDTH +: AWIDTH];
            word = '0;
            if (!busy && ({1'b0, rak} < DEPTH_W)) begin
                word = mem[rak];
                if (WR_FWD && we && (rak == wa)) begin
                    for (int unsigned i = 0; i < NBYTE; i++) begin
                        if (wbe[i]) word[8*i +: 8] = wd[8*i +: 8];
                    end
                end
            end
            rd[k*DWIDTH +: DWIDTH] = word;
        end
    end

endmodule

// File: doc/ram_1w_nr_clr.md
# ram_1w_nr_clr

Multi-read-port distributed RAM with one byte-enabled synchronous write port, NRD asynchronous read ports, optional write-to-read forwarding, and a built-in clear engine that sweeps every word to a fixed value after reset or on request. It replaces single-port async-read storage wherever register-file-like structures need several concurrent combinational reads and a known power-up state. Typical users are scoreboards, tag arrays and small register files.

## Interface
- DWIDTH, 32: data width in bits; must be a multiple of 8 (elaboration error otherwise).
- AWIDTH, 6: address width.
- DEPTH, 1 << AWIDTH: number of words; 1 <= DEPTH <= 2^AWIDTH.
- NRD, 2: number of asynchronous read ports, >= 1.
- WR_FWD, 0: 1 = same-cycle write data forwarded to matching read ports; 0 = reads show stored contents.
- CLR_VAL, 0: DWIDTH-bit value written to every word by the clear engine.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- clr  in  1  clear request; sampled when idle.
- busy  out  1  high while the clear engine owns the array.
- we  in  1  write enable.
- wbe  in  DWIDTH/8  byte enables; bit i covers wd[8i+7:8i].
- wa  in  AWIDTH  write address.
- wd  in  DWIDTH  write data.
- ra  in  NRD*AWIDTH  packed read addresses; port k = ra[k*AWIDTH +: AWIDTH].
- rd  out  NRD*DWIDTH  packed read data; port k = rd[k*DWIDTH +: DWIDTH].

## Operation
- Storage: DEPTH x DWIDTH array, distributed-RAM style, no initial-block contents; the clear engine defines the contents.
- Clear FSM, two states:
  - CLEAR: writes CLR_VAL to mem[cnt], then cnt <= cnt+1. When cnt == DEPTH-1 is written, the next state is IDLE.
  - IDLE: clr == 1 moves the FSM to CLEAR with cnt <= 0.
- Reset: rst_n low at an edge forces state = CLEAR and cnt = 0, and suppresses all array writes that edge. Array contents are not otherwise touched during reset.
- clr while in CLEAR is ignored; there is no restart and no queuing.
- Reset asserted mid-clear restarts the sweep at word 0.
- User write (IDLE only): at a rising edge with we = 1, wa < DEPTH and rst_n = 1, byte i of mem[wa] is updated iff wbe[i] = 1. wbe = 0 is a no-op.
- Dropped writes, with no error flag:
  - writes while busy;
  - writes to wa >= DEPTH.
- Read port k (combinational):
  - rd_k = 0 if busy = 1 or ra_k >= DEPTH;
  - otherwise rd_k = mem[ra_k];
  - when WR_FWD = 1, !busy, we = 1 and ra_k == wa < DEPTH, rd_k takes wd for bytes with wbe[i] = 1 and mem[wa] for all other bytes.
- All read ports are independent; any ports may share an address.

## Timing
- Reset values: busy = 1, state = CLEAR, cnt = 0, rd = 0 (forced by busy).
- Clear latency: busy stays high for exactly DEPTH cycles after the first edge with rst_n = 1. It is also high for DEPTH cycles starting the cycle after an edge where clr was sampled in IDLE.
- busy is registered: it is driven from the FSM state, not from clr.
- A write becomes visible on rd the cycle after the write edge. It is visible in the same cycle only when WR_FWD = 1.
- The first user write is accepted at the first edge where busy = 0 in the preceding cycle.
- clr and we both high in IDLE: the write is performed at that edge. The sweep then starts, and the written word is overwritten by CLR_VAL in its turn.
- Read path: purely combinational from ra, wa, we, wbe, wd and state. There is no read latency.

## Test plan
- Reset sweep: DEPTH = 64, CLR_VAL = 32'hDEAD_BEEF. Hold rst_n low 3 cycles, then release. Expect busy = 1 for exactly 64 cycles. Afterwards every address reads DEAD_BEEF on both ports; rd = 0 throughout busy.
- Byte enables: write 32'h1122_3344 with wbe = 4'b1111 to addr 5, then 32'hAABB_CCDD with wbe = 4'b0101 to addr 5. Expect 32'h11BB_33DD the next cycle.
- Forwarding:
  - WR_FWD = 1: ra0 = wa = 7, we = 1, wd = 32'hCAFE_F00D, wbe = 4'b1100, mem[7] = 0. Expect rd0 = 32'hCAFE_0000 in the same cycle.
  - WR_FWD = 0: expect 0 in that cycle and 32'hCAFE_0000 in the next.
- Dropped writes: during busy, write 32'h5 to addr 3. After the clear completes, addr 3 reads CLR_VAL. With DEPTH = 48, AWIDTH = 6, a write to addr 50 changes nothing and reading addr 50 returns 0.
- clr handling:
  - Pulse clr in IDLE after filling the array with nonzero data. Expect busy high for DEPTH cycles, then all words = CLR_VAL.
  - Pulse clr again mid-sweep. Expect no extension of busy.
- Reset mid-clear: assert rst_n low at sweep cycle 20, release after 1 cycle. Expect busy to remain high for a full DEPTH cycles from release, and all words = CLR_VAL.
